flag_event_monitor: RTL and testbench
=====================================

FLAG_EVENT_MONITOR -- requirements
Module: flag_event_monitor

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, giving the per-flag event counter width (legal 2..16).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, reset; reset is asynchronous and active-high.
REQ-004 The module SHALL have ports in_and, in_or, in_not, in_complex, input, 1 each, combinational logic flags from the upstream logic stage (indices 0..3).
REQ-005 The module SHALL have port clear, input, 1, synchronous zeroing of all counters.
REQ-006 The module SHALL have port rd_req, input, 1, readout request.
REQ-007 The module SHALL have port rd_sel, input, 2, counter index for the request.
REQ-008 The module SHALL have port rd_valid, output, 1, readout data valid.
REQ-009 The module SHALL have port rd_ready, input, 1, consumer accepts readout.
REQ-010 The module SHALL have port rd_data, output, CNT_W, selected counter snapshot.
REQ-011 The module SHALL have port busy, output, 1, high whenever the read FSM is not IDLE.

Function
REQ-012 Each flag SHALL pass through a 2-flop synchronizer; a rising edge SHALL be detected when the synchronized value is 1 and its previous registered value is 0.
REQ-013 Counter i SHALL increment by 1 on the cycle after an edge of flag i; it SHALL saturate at 2^CNT_W-1 without wrap.
REQ-014 clear SHALL zero all counters on the next edge; clear SHALL take priority over a same-cycle increment; synchronizer and edge-history flops SHALL NOT be cleared.
REQ-015 Read FSM states SHALL be IDLE, LOAD, HOLD.
REQ-016 IDLE: rd_req=1 latches rd_sel and moves to LOAD; rd_req outside IDLE SHALL be ignored.
REQ-017 LOAD: rd_data captures the latched counter's current registered value (pre-increment of that cycle), rd_valid goes 1, moves to HOLD.
REQ-018 HOLD: rd_data and rd_valid SHALL stay stable until rd_ready=1, then rd_valid drops and FSM returns to IDLE.
REQ-019 Latency: rd_valid SHALL assert exactly 2 cycles after rd_req is sampled in IDLE.
REQ-020 clear or counter increments during HOLD SHALL NOT alter rd_data.
REQ-021 A flag that is high when reset releases SHALL count as one edge once it propagates through the synchronizer.

Reset
REQ-022 Reset SHALL set counters, synchronizer and edge-history flops, rd_data, rd_valid, and latched rd_sel to 0, and the FSM to IDLE; busy SHALL read 0.
REQ-023 Reset asserted mid-readout SHALL abort the transaction immediately; no rd_valid SHALL follow.

Configuration
REQ-024 With macro FLAG_EVENT_MONITOR_OVF_EN defined, output port ovf[3:0] SHALL exist; bit i sets when counter i is at maximum and another edge arrives, is sticky, is cleared by clear or rst, and resets to 0.
REQ-025 Without FLAG_EVENT_MONITOR_OVF_EN, no ovf port or logic SHALL exist; saturation behaviour SHALL be identical.

Structure
REQ-026 Package flag_event_monitor_pkg SHALL hold the FSM state enum and flag index constants IDX_AND=0, IDX_OR=1, IDX_NOT=2, IDX_COMPLEX=3.
REQ-027 Sub-module flag_edge_sync (2-flop sync plus rising-edge pulse) SHALL be instantiated once per flag.

Verification
REQ-028 Three pulses on in_and, each 3 cycles high and 3 cycles low; then rd_req with rd_sel=0 -> rd_valid 2 cycles later, rd_data=3.
REQ-029 CNT_W=2, five in_or edges -> rd_sel=1 reads 3; with OVF_EN, ovf=4'b0010.
REQ-030 An in_not edge and clear arriving the same cycle -> counter 2 reads 0.
REQ-031 rd_ready held 0 for 10 cycles while in_complex toggles and a second rd_req is issued -> rd_data constant, busy=1, second request ignored.
REQ-032 rst asserted while in LOAD -> rd_valid stays 0, busy=0, all counters read 0 after release.

Source files
------------

// File: rtl/flag_event_monitor_pkg.sv
// Shared types and constants for the flag event monitor.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package flag_event_monitor_pkg;

  localparam int NUM_FLAGS   = 4;

  localparam int IDX_AND     = 0;
  localparam int IDX_OR      = 1;
  localparam int IDX_NOT     = 2;
  localparam int IDX_COMPLEX = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } rd_state_t;

endpackage

// File: rtl/flag_edge_sync.sv
// Two-flop synchronizer for one asynchronous flag plus a rising-edge pulse.
// Latency: rise pulses for one cycle, two clocks after the flag goes high.
// Backpressure: none; every synchronized low-to-high transition produces a pulse.
module flag_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic flag,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronizer stages and the one-cycle history used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= flag;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // A flag held high through reset release still sees prev=0, so it counts once.
  assign rise = sync2 & ~prev;

endmodule

// File: rtl/flag_event_monitor.sv
// Counts rising edges on four logic flags with saturating counters and a snapshot readout port.
// Latency: rd_valid rises 2 cycles after rd_req is taken in IDLE; counters update the cycle after an edge.
// Backpressure: rd_data/rd_valid hold until rd_ready; optional sticky ovf under FLAG_EVENT_MONITOR_OVF_EN.
module flag_event_monitor
  import flag_event_monitor_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_and,
  input  logic             in_or,
  input  logic             in_not,
  input  logic             in_complex,
  input  logic             clear,
  input  logic             rd_req,
  input  logic [1:0]       rd_sel,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CNT_W-1:0] rd_data,
  output logic             busy
`ifdef FLAG_EVENT_MONITOR_OVF_EN
  ,
  output logic [3:0]       ovf
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_FLAGS-1:0] flags;
  logic [NUM_FLAGS-1:0] rise;
  logic [CNT_W-1:0]     cnt [NUM_FLAGS];
  rd_state_t            state;
  rd_state_t            state_nxt;
  logic [1:0]           sel_q;
  logic                 sel_load;
  logic                 snap_load;
  logic                 rd_done;

  assign flags[IDX_AND]     = in_and;
  assign flags[IDX_OR]      = in_or;
  assign flags[IDX_NOT]     = in_not;
  assign flags[IDX_COMPLEX] = in_complex;

  for (genvar g = 0; g < NUM_FLAGS; g++) begin : g_sync
    flag_edge_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .flag (flags[g]),
      .rise (rise[g])
    );
  end

  // Event counters: clear wins over a same-cycle edge, otherwise saturating increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FLAGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_FLAGS; i++) begin
        if (clear) begin
          cnt[i] <= '0;
        end else if (rise[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

`ifdef FLAG_EVENT_MONITOR_OVF_EN
  // Sticky overflow: an edge arrived while its counter was already saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 4'b0000;
    end else begin
      for (int i = 0; i < NUM_FLAGS; i++) begin
        if (clear) begin
          ovf[i] <= 1'b0;
        end else if (rise[i] && (cnt[i] == CNT_MAX)) begin
          ovf[i] <= 1'b1;
        end
      end
    end
  end
`endif

  // Read FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Read FSM next state and datapath strobes; requests outside IDLE are dropped.
  always_comb begin
    state_nxt = state;
    sel_load  = 1'b0;
    snap_load = 1'b0;
    rd_done   = 1'b0;
    case (state)
      IDLE: begin
        if (rd_req) begin
          sel_load  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        snap_load = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        if (rd_ready) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Readout datapath: snapshot taken once in LOAD, so later clears/increments cannot disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q    <= 2'd0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (sel_load) begin
        sel_q <= rd_sel;
      end
      if (snap_load) begin
        rd_data  <= cnt[sel_q];
        rd_valid <= 1'b1;
      end else if (rd_done) begin
        rd_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_flag_event_monitor.sv
// Directed bench for flag_event_monitor: one CNT_W=8 and one CNT_W=2 instance driven in lockstep.
// Latency: readout expected exactly 2 cycles after rd_req.
// Backpressure: rd_ready is held low to check snapshot stability.
module tb_flag_event_monitor;

  logic       clk;
  logic       rst;
  logic       in_and;
  logic       in_or;
  logic       in_not;
  logic       in_complex;
  logic       clear;
  logic       rd_req;
  logic [1:0] rd_sel;
  logic       rd_ready;

  logic       rd_valid8;
  logic [7:0] rd_data8;
  logic       busy8;
  logic       rd_valid2;
  logic [1:0] rd_data2;
  logic       busy2;
`ifdef FLAG_EVENT_MONITOR_OVF_EN
  logic [3:0] ovf8;
  logic [3:0] ovf2;
`endif

  int errors = 0;
  int checks = 0;

  flag_event_monitor #(.CNT_W(8)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .in_and     (in_and),
    .in_or      (in_or),
    .in_not     (in_not),
    .in_complex (in_complex),
    .clear      (clear),
    .rd_req     (rd_req),
    .rd_sel     (rd_sel),
    .rd_valid   (rd_valid8),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data8),
    .busy       (busy8)
`ifdef FLAG_EVENT_MONITOR_OVF_EN
    ,
    .ovf        (ovf8)
`endif
  );

  flag_event_monitor #(.CNT_W(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .in_and     (in_and),
    .in_or      (in_or),
    .in_not     (in_not),
    .in_complex (in_complex),
    .clear      (clear),
    .rd_req     (rd_req),
    .rd_sel     (rd_sel),
    .rd_valid   (rd_valid2),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data2),
    .busy       (busy2)
`ifdef FLAG_EVENT_MONITOR_OVF_EN
    ,
    .ovf        (ovf2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_flag(input int which, input logic v);
    case (which)
      0: in_and = v;
      1: in_or = v;
      2: in_not = v;
      default: in_complex = v;
    endcase
  endtask

  // n pulses, each 3 cycles high and 3 cycles low
  task automatic flag_pulses(input int which, input int n);
    for (int k = 0; k < n; k++) begin
      set_flag(which, 1'b1);
      ticks(3);
      set_flag(which, 1'b0);
      ticks(3);
    end
  endtask

  // Full readout with exact-latency checks on both instances.
  task automatic do_read(input logic [1:0] sel, input logic [7:0] e8, input logic [1:0] e2,
                         input string tag);
    rd_sel = sel;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk({tag, "_valid_c1"}, {31'd0, rd_valid8}, 32'd0);
    chk({tag, "_busy_c1"}, {31'd0, busy8}, 32'd1);
    tick();
    chk({tag, "_valid_c2"}, {31'd0, rd_valid8}, 32'd1);
    chk({tag, "_data8"}, {24'd0, rd_data8}, {24'd0, e8});
    chk({tag, "_valid2_c2"}, {31'd0, rd_valid2}, 32'd1);
    chk({tag, "_data2"}, {30'd0, rd_data2}, {30'd0, e2});
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk({tag, "_valid_done"}, {31'd0, rd_valid8}, 32'd0);
    chk({tag, "_busy_done"}, {31'd0, busy8}, 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    in_and     = 1'b0;
    in_or      = 1'b0;
    in_not     = 1'b0;
    in_complex = 1'b1;   // high across reset release: must count once
    clear      = 1'b0;
    rd_req     = 1'b0;
    rd_sel     = 2'd0;
    rd_ready   = 1'b0;

    // Reset state
    ticks(3);
    chk("rst_valid", {31'd0, rd_valid8}, 32'd0);
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_data8", {24'd0, rd_data8}, 32'd0);
    chk("rst_data2", {30'd0, rd_data2}, 32'd0);
`ifdef FLAG_EVENT_MONITOR_OVF_EN
    chk("rst_ovf8", {28'd0, ovf8}, 32'd0);
    chk("rst_ovf2", {28'd0, ovf2}, 32'd0);
`endif
    rst = 1'b0;
    ticks(4);

    // Three in_and pulses -> counter 0 = 3 on both widths
    flag_pulses(0, 3);
    ticks(2);
    do_read(2'd0, 8'd3, 2'd3, "and3");

    // Flag high at reset release counted exactly once
    do_read(2'd3, 8'd1, 2'd1, "cplx_rst_edge");
    in_complex = 1'b0;
    ticks(3);

    // clear zeroes counters
    clear = 1'b1;
    tick();
    clear = 1'b0;
    do_read(2'd0, 8'd0, 2'd0, "after_clear");

    // Five in_or edges: 5 on wide counter, saturates at 3 on narrow one
    flag_pulses(1, 5);
    ticks(2);
    do_read(2'd1, 8'd5, 2'd3, "or5");
`ifdef FLAG_EVENT_MONITOR_OVF_EN
    chk("or5_ovf2", {28'd0, ovf2}, 32'h2);
    chk("or5_ovf8", {28'd0, ovf8}, 32'h0);
`endif

    // in_not edge pulse coincides with clear: clear wins
    in_not = 1'b1;
    ticks(2);            // edge pulse now active combinationally
    clear = 1'b1;
    tick();
    clear = 1'b0;
    ticks(3);
    do_read(2'd2, 8'd0, 2'd0, "not_vs_clear");
    do_read(2'd1, 8'd0, 2'd0, "or_cleared");
`ifdef FLAG_EVENT_MONITOR_OVF_EN
    chk("clear_ovf2", {28'd0, ovf2}, 32'h0);
`endif
    in_not = 1'b0;
    ticks(3);

    // Hold readout with rd_ready low while in_complex toggles and a 2nd request arrives
    flag_pulses(3, 2);
    ticks(2);
    rd_sel = 2'd3;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    chk("hold_start_valid", {31'd0, rd_valid8}, 32'd1);
    chk("hold_start_data", {24'd0, rd_data8}, 32'd2);
    for (int i = 0; i < 10; i++) begin
      in_complex = ((i % 4) >= 2);
      rd_req     = (i == 3);
      rd_sel     = 2'd0;
      tick();
      chk($sformatf("hold_data_%0d", i), {24'd0, rd_data8}, 32'd2);
      chk($sformatf("hold_valid_%0d", i), {31'd0, rd_valid8}, 32'd1);
      chk($sformatf("hold_busy_%0d", i), {31'd0, busy8}, 32'd1);
    end
    rd_req = 1'b0;
    in_complex = 1'b0;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    chk("hold_end_valid", {31'd0, rd_valid8}, 32'd0);
    chk("hold_end_busy", {31'd0, busy8}, 32'd0);
    ticks(2);
    chk("second_req_ignored", {31'd0, busy8}, 32'd0);
    ticks(2);
    do_read(2'd3, 8'd4, 2'd3, "cplx4");
`ifdef FLAG_EVENT_MONITOR_OVF_EN
    chk("cplx_ovf2", {28'd0, ovf2}, 32'h8);
    chk("cplx_ovf8", {28'd0, ovf8}, 32'h0);
`endif

    // Reset during LOAD aborts the readout
    rd_sel = 2'd3;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy8}, 32'd0);
    chk("abort_valid", {31'd0, rd_valid8}, 32'd0);
    ticks(2);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("abort_no_valid_%0d", i), {31'd0, rd_valid8}, 32'd0);
    end
    for (int s = 0; s < 4; s++) begin
      do_read(2'(s), 8'd0, 2'd0, $sformatf("post_rst_cnt%0d", s));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
